// File: rtl/apb_requester_bridge.sv
// APB requester bridge: takes a single-cycle request packet, runs one APB
// transfer (SETUP then ACCESS until PREADY or timeout) and reports the
// completion with one-cycle pulses. Every output comes straight from a flop.
//
// Handshake: H_Valid is a one-cycle pulse that is accepted only in IDLE; a
// pulse in any other state is discarded and flagged on Drop_Err one cycle
// later. There is no back-pressure signal. A completion is a one-cycle pulse
// on Bridge_Ready (write) or Bridge_Rd_Valid (read), with Bridge_Err alongside.
module apb_requester_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        HCLK,
   input  logic        RESETn,
   input  logic [40:0] Packet_In,
   input  logic        H_Valid,
   output logic        Bridge_Ready,
   output logic        Bridge_Rd_Valid,
   output logic [31:0] Bridge_Rd_Data,
   output logic        Bridge_Err,
   output logic        Drop_Err,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [7:0]  PADDR,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Counter is compared one bit wider so the incremented value never wraps
   // before it is checked against the limit.
   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [8:0]  cnt_inc;
   logic [7:0]  paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        pwrite_q, pwrite_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        ready_q, ready_d;
   logic        rd_valid_q, rd_valid_d;
   logic        berr_q, berr_d;
   logic        drop_q, drop_d;
   logic        xfer_err;

   assign cnt_inc = {1'b0, cnt_q} + 9'd1;

   // Next-state logic; output flops are loaded from the state being entered
   // so that PSEL/PENABLE/pulses line up with the registered state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      rd_data_d = rd_data_q;
      xfer_err  = 1'b0;
      drop_d    = H_Valid && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (H_Valid) begin
               pwrite_d = Packet_In[40];
               pwdata_d = Packet_In[39:8];
               paddr_d  = Packet_In[7:0];
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = 8'd0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               // A ready completer wins over a timeout reached this cycle.
               xfer_err = PSLVERR;
               if (!pwrite_q) begin
                  rd_data_d = PRDATA;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_inc[7:0];
               if ((TO_LIMIT != 9'd0) && (cnt_inc == TO_LIMIT)) begin
                  xfer_err = 1'b1;
                  if (!pwrite_q) begin
                     rd_data_d = 32'h0000_0000;
                  end
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      psel_d     = (state_d == SETUP) || (state_d == ACCESS);
      penable_d  = (state_d == ACCESS);
      ready_d    = (state_d == RESP) && pwrite_q;
      rd_valid_d = (state_d == RESP) && !pwrite_q;
      berr_d     = (state_d == RESP) && xfer_err;
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge HCLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         paddr_q    <= 8'd0;
         pwdata_q   <= 32'd0;
         pwrite_q   <= 1'b0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         rd_data_q  <= 32'd0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         berr_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         pwrite_q   <= pwrite_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         rd_data_q  <= rd_data_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         berr_q     <= berr_d;
         drop_q     <= drop_d;
      end
   end

   assign PSEL            = psel_q;
   assign PENABLE         = penable_q;
   assign PWRITE          = pwrite_q;
   assign PADDR           = paddr_q;
   assign PWDATA          = pwdata_q;
   assign Bridge_Ready    = ready_q;
   assign Bridge_Rd_Valid = rd_valid_q;
   assign Bridge_Rd_Data  = rd_data_q;
   assign Bridge_Err      = berr_q;
   assign Drop_Err        = drop_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_apb_requester_bridge.sv
// Bench for apb_requester_bridge (built with TIMEOUT_CYCLES=4). Each scenario
// task drives one or more transfers and checks timing inline; completions are
// also checked by a monitor against an expected queue filled by the tasks.
module tb_apb_requester_bridge;

   localparam int W = 34; // {is_read, err, read_data}

   logic        HCLK;
   logic        RESETn;
   logic [40:0] Packet_In;
   logic        H_Valid;
   logic        Bridge_Ready;
   logic        Bridge_Rd_Valid;
   logic [31:0] Bridge_Rd_Data;
   logic        Bridge_Err;
   logic        Drop_Err;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [1:0]  dbg_state_o;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_obs;

   apb_requester_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .HCLK            (HCLK),
      .RESETn          (RESETn),
      .Packet_In       (Packet_In),
      .H_Valid         (H_Valid),
      .Bridge_Ready    (Bridge_Ready),
      .Bridge_Rd_Valid (Bridge_Rd_Valid),
      .Bridge_Rd_Data  (Bridge_Rd_Data),
      .Bridge_Err      (Bridge_Err),
      .Drop_Err        (Drop_Err),
      .PSEL            (PSEL),
      .PENABLE         (PENABLE),
      .PWRITE          (PWRITE),
      .PADDR           (PADDR),
      .PWDATA          (PWDATA),
      .PRDATA          (PRDATA),
      .PREADY          (PREADY),
      .PSLVERR         (PSLVERR),
      .dbg_state_o     (dbg_state_o)
   );

   // Clock / reset
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Completion monitor: every pulse must match the oldest expected entry.
   always @(negedge HCLK) begin
      if (RESETn) begin
         if (Bridge_Ready || Bridge_Rd_Valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_completion rdy=%0b rdv=%0b err=%0b required none", Bridge_Ready, Bridge_Rd_Valid, Bridge_Err);
            end else begin
               mon_exp = exp_q.pop_front();
               mon_obs = {Bridge_Rd_Valid, Bridge_Err, (Bridge_Rd_Valid ? Bridge_Rd_Data : 32'h0)};
               if (mon_obs !== mon_exp) begin
                  errors++;
                  $display("FAIL completion got %h required %h", mon_obs, mon_exp);
               end
            end
            checks++;
            if (Bridge_Ready && Bridge_Rd_Valid) begin
               errors++;
               $display("FAIL both_pulses got rdy=1 rdv=1 required one of them");
            end
         end else if (Bridge_Err) begin
            checks++;
            errors++;
            $display("FAIL stray_err got Bridge_Err=1 required 0 outside completion");
         end
      end
   end

   // Driver: one request; returns completion cycle relative to H_Valid cycle.
   task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic slverr, input int low_cycles,
                           input int drop_at, output int lat, output int n_access,
                           output int drop_cyc, output bit addr_stable);
      int cyc;
      bit done;
      lat = -1; n_access = 0; drop_cyc = -1; addr_stable = 1'b1;
      @(posedge HCLK); #1;
      Packet_In = {wr, wdata, addr};
      H_Valid   = 1'b1;
      PREADY    = 1'b0;
      PSLVERR   = slverr;
      PRDATA    = rdata;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
         @(posedge HCLK); #1;
         cyc++;
         H_Valid = (cyc == drop_at);
         if (cyc == drop_at) Packet_In = {~wr, ~wdata, ~addr};
         if (Drop_Err && drop_cyc < 0) drop_cyc = cyc;
         if (PSEL && (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr)) addr_stable = 1'b0;
         if (PSEL && PENABLE) n_access++;
         PREADY = (cyc == 2 + low_cycles);
         if (Bridge_Ready || Bridge_Rd_Valid) begin
            lat    = cyc;
            done   = 1'b1;
            PREADY = 1'b0;
         end
      end
      H_Valid = 1'b0;
   endtask

   task automatic test_reset();
      RESETn = 1'b0; Packet_In = '0; H_Valid = 1'b0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, Bridge_Ready, Bridge_Rd_Valid, Bridge_Rd_Data, Bridge_Err, Drop_Err, dbg_state_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got psel=%0b pen=%0b addr=%h rdy=%0b rdv=%0b st=%0d required all 0",
                  PSEL, PENABLE, PADDR, Bridge_Ready, Bridge_Rd_Valid, dbg_state_o);
      end
      RESETn = 1'b1;
   endtask

   task automatic test_write();
      int lat;
      @(posedge HCLK); #1;
      Packet_In = {1'b1, 32'hA5A5_1234, 8'h3C}; H_Valid = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 32'h0});
      @(posedge HCLK); #1; H_Valid = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 8'h3C, 32'hA5A5_1234}) begin
         errors++;
         $display("FAIL write_setup got sel=%0b en=%0b wr=%0b a=%h d=%h required 1 0 1 3c a5a51234", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      @(posedge HCLK); #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b1, 1'b1, 8'h3C, 32'hA5A5_1234}) begin
         errors++;
         $display("FAIL write_access got sel=%0b en=%0b wr=%0b a=%h d=%h required 1 1 1 3c a5a51234", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      @(posedge HCLK); #1; PREADY = 1'b0;
      checks++;
      if ({Bridge_Ready, Bridge_Err, PSEL, PENABLE} !== 4'b1000) begin
         errors++;
         $display("FAIL write_n3 got rdy=%0b err=%0b sel=%0b en=%0b required 1 0 0 0", Bridge_Ready, Bridge_Err, PSEL, PENABLE);
      end
      @(posedge HCLK); #1;
      checks++;
      if ({Bridge_Ready, dbg_state_o} !== 3'b000) begin
         errors++;
         $display("FAIL write_n4 got rdy=%0b st=%0d required 0 0", Bridge_Ready, dbg_state_o);
      end
   endtask

   // Three PREADY-low cycles means completion on the 4th ACCESS cycle, the
   // same cycle the timeout limit of 4 is reached: must be a normal completion.
   task automatic test_read_wait();
      int lat, nacc, dcyc;
      bit stable;
      exp_q.push_back({1'b1, 1'b0, 32'hCAFE_F00D});
      run_xfer(1'b0, 8'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 0, lat, nacc, dcyc, stable);
      checks++;
      if (lat !== 6 || nacc !== 4) begin
         errors++;
         $display("FAIL read_wait_latency got lat=%0d acc=%0d required 6 4", lat, nacc);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL read_wait_stable got changed PADDR/PWDATA/PWRITE required stable");
      end
      PRDATA = 32'h1111_2222;
      repeat (2) @(posedge HCLK);
      #1;
      checks++;
      if ({Bridge_Rd_Valid, Bridge_Rd_Data} !== {1'b0, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL read_hold got rdv=%0b data=%h required 0 cafef00d", Bridge_Rd_Valid, Bridge_Rd_Data);
      end
   endtask

   task automatic test_slverr();
      int lat, nacc, dcyc;
      bit stable;
      exp_q.push_back({1'b1, 1'b1, 32'h1234_5678});
      run_xfer(1'b0, 8'h20, 32'h0, 32'h1234_5678, 1'b1, 0, 0, lat, nacc, dcyc, stable);
      checks++;
      if (lat !== 3 || Bridge_Err !== 1'b1) begin
         errors++;
         $display("FAIL slverr_pulse got lat=%0d err=%0b required 3 1", lat, Bridge_Err);
      end
      PSLVERR = 1'b0;
      @(posedge HCLK); #1;
      checks++;
      if ({Bridge_Rd_Valid, Bridge_Err} !== 2'b00) begin
         errors++;
         $display("FAIL slverr_single got rdv=%0b err=%0b required 0 0", Bridge_Rd_Valid, Bridge_Err);
      end
   endtask

   task automatic test_timeout();
      int lat, nacc, dcyc;
      bit stable;
      exp_q.push_back({1'b1, 1'b1, 32'h0});
      run_xfer(1'b0, 8'h55, 32'h0, 32'hDEAD_BEEF, 1'b0, 100, 0, lat, nacc, dcyc, stable);
      checks++;
      if (lat !== 6 || nacc !== 4 || PSEL !== 1'b0 || Bridge_Rd_Data !== 32'h0) begin
         errors++;
         $display("FAIL rd_timeout got lat=%0d acc=%0d sel=%0b data=%h required 6 4 0 0", lat, nacc, PSEL, Bridge_Rd_Data);
      end
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      run_xfer(1'b1, 8'h66, 32'h7777_8888, 32'h0, 1'b0, 100, 0, lat, nacc, dcyc, stable);
      checks++;
      if (lat !== 6 || nacc !== 4 || Bridge_Err !== 1'b1) begin
         errors++;
         $display("FAIL wr_timeout got lat=%0d acc=%0d err=%0b required 6 4 1", lat, nacc, Bridge_Err);
      end
   endtask

   task automatic test_drop();
      int lat, nacc, dcyc;
      bit stable;
      exp_q.push_back({1'b1, 1'b0, 32'h0BAD_CAFE});
      run_xfer(1'b0, 8'h77, 32'h0000_0042, 32'h0BAD_CAFE, 1'b0, 2, 3, lat, nacc, dcyc, stable);
      checks++;
      if (dcyc !== 4 || lat !== 5 || !stable) begin
         errors++;
         $display("FAIL drop_access got drop=%0d lat=%0d stable=%0b required 4 5 1", dcyc, lat, stable);
      end
      exp_q.push_back({1'b0, 1'b0, 32'h0});
      run_xfer(1'b1, 8'h81, 32'h9999_0001, 32'h0, 1'b0, 0, 1, lat, nacc, dcyc, stable);
      checks++;
      if (dcyc !== 2 || lat !== 3 || !stable) begin
         errors++;
         $display("FAIL drop_setup got drop=%0d lat=%0d stable=%0b required 2 3 1", dcyc, lat, stable);
      end
      repeat (3) @(posedge HCLK);
      #1;
      checks++;
      if ({PSEL, Drop_Err, dbg_state_o} !== 4'b0000) begin
         errors++;
         $display("FAIL drop_no_xfer got sel=%0b drop=%0b st=%0d required 0 0 0", PSEL, Drop_Err, dbg_state_o);
      end
   endtask

   task automatic test_back_to_back();
      int lat, nacc, dcyc;
      bit stable;
      exp_q.push_back({1'b0, 1'b0, 32'h0});
      run_xfer(1'b1, 8'h01, 32'h0101_0101, 32'h0, 1'b0, 0, 0, lat, nacc, dcyc, stable);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL b2b_write got lat=%0d required 3", lat);
      end
      for (int i = 0; i < 3; i++) begin
         logic [31:0] d;
         logic [7:0]  a;
         int          low;
         d   = $urandom;
         a   = 8'($urandom_range(0, 255));
         low = $urandom_range(0, 2);
         exp_q.push_back({1'b1, 1'b0, d});
         run_xfer(1'b0, a, 32'h0, d, 1'b0, low, 0, lat, nacc, dcyc, stable);
         checks++;
         if (lat !== 3 + low || !stable) begin
            errors++;
            $display("FAIL b2b_read%0d got lat=%0d stable=%0b required %0d 1", i, lat, stable, 3 + low);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, nacc, dcyc;
      bit stable;
      @(posedge HCLK); #1;
      Packet_In = {1'b0, 32'h0, 8'h44}; H_Valid = 1'b1; PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
      @(posedge HCLK); #1; H_Valid = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      checks++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid_access got sel=%0b en=%0b required 1 1", PSEL, PENABLE);
      end
      RESETn = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, PADDR, Bridge_Ready, Bridge_Rd_Valid, Bridge_Rd_Data, Bridge_Err, Drop_Err, dbg_state_o} !== '0) begin
         errors++;
         $display("FAIL rstmid_async got sel=%0b en=%0b addr=%h rdata=%h st=%0d required all 0", PSEL, PENABLE, PADDR, Bridge_Rd_Data, dbg_state_o);
      end
      repeat (2) @(posedge HCLK);
      #1;
      RESETn = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 32'h0});
      run_xfer(1'b1, 8'h3C, 32'hA5A5_1234, 32'h0, 1'b0, 0, 0, lat, nacc, dcyc, stable);
      checks++;
      if (lat !== 3 || !stable) begin
         errors++;
         $display("FAIL rstmid_after got lat=%0d stable=%0b required 3 1", lat, stable);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      repeat (4) @(posedge HCLK);
      #1;
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL pending_completions got %0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
